// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: framed multi-operand accumulator.
// Operands are folded into a carry-save total (sum and carry vectors), so each
// beat costs one full-adder level regardless of ACC_W. At end of frame a
// CHUNK-wide ripple adder resolves the total over ACC_W/CHUNK cycles. The
// result is then held on a valid/ready output together with the operand count
// and an exact overflow flag.
module csa_stream_accumulator #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 12,
   parameter int CHUNK = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam int NCH   = ACC_W / CHUNK;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;

   state_t           state;
   state_t           state_next;
   logic [ACC_W-1:0] s;
   logic [ACC_W-1:0] c;
   logic [ACC_W-1:0] x;
   logic [ACC_W-1:0] t;
   logic [ACC_W-1:0] m;
   logic [IDX_W-1:0] idx;
   logic [31:0]      base;
   logic             cy;
   logic [CHUNK-1:0] chunk_s;
   logic [CHUNK-1:0] chunk_c;
   logic [CHUNK-1:0] chunk_sum;
   logic [CHUNK:0]   rip;
   logic             accept;
   logic             handshake;
   logic             last_chunk;

   assign accept     = in_valid && in_ready;
   assign handshake  = out_valid && out_ready;
   assign last_chunk = (idx == IDX_W'(NCH - 1));
   assign base       = 32'(idx) * CHUNK;

   // One carry-save level: fold the zero-extended operand into S and C.
   always_comb begin
      x = ACC_W'(in_data);
      t = s ^ c ^ x;
      m = (s & c) | (s & x) | (c & x);
   end

   // Ripple full-adder chain for the chunk currently being resolved.
   always_comb begin
      chunk_s   = s[base +: CHUNK];
      chunk_c   = c[base +: CHUNK];
      chunk_sum = '0;
      rip       = '0;
      rip[0]    = cy;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_sum[i] = chunk_s[i] ^ chunk_c[i] ^ rip[i];
         rip[i+1]     = (chunk_s[i] & chunk_c[i]) | (chunk_s[i] & rip[i]) |
                        (chunk_c[i] & rip[i]);
      end
   end

   // Frame sequencing: accumulate, resolve chunk by chunk, then hold the result.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = in_last ? RESOLVE : ACCUM;
         ACCUM:   if (accept && in_last) state_next = RESOLVE;
         RESOLVE: if (last_chunk) state_next = OUTPUT;
         OUTPUT:  if (handshake) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register plus registered handshake outputs; out_valid trails OUTPUT entry by one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next == IDLE) || (state_next == ACCUM);
         out_valid <= (state == OUTPUT) && !handshake;
      end
   end

   // Datapath: carry-save accumulation, chunked resolve, and clear after delivery.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s         <= '0;
         c         <= '0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         idx       <= '0;
         cy        <= 1'b0;
      end else if (accept) begin
         s <= t;
         c <= m << 1;
         if (m[ACC_W-1]) out_ovf <= 1'b1;
         if (out_count != {CNT_W{1'b1}}) out_count <= out_count + CNT_W'(1);
      end else if (state == RESOLVE) begin
         out_sum[base +: CHUNK] <= chunk_sum;
         if (last_chunk) begin
            idx <= '0;
            cy  <= 1'b0;
            if (rip[CHUNK]) out_ovf <= 1'b1;
         end else begin
            idx <= idx + IDX_W'(1);
            cy  <= rip[CHUNK];
         end
      end else if (handshake) begin
         s         <= '0;
         c         <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         cy        <= 1'b0;
      end
   end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed testbench for csa_stream_accumulator with hand-computed results.
// A second instance with CNT_W = 2 shares the stimulus to exercise count saturation.
module tb_csa_stream_accumulator;

   localparam int WIDTH = 8;
   localparam int ACC_W = 12;
   localparam int CHUNK = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;
   logic             in_ready2;
   logic             out_valid2;
   logic [ACC_W-1:0] out_sum2;
   logic [1:0]       out_count2;
   logic             out_ovf2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   csa_stream_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
   );

   csa_stream_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(CHUNK), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
      .out_ready(out_ready), .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Present one operand and return just after the edge that accepts it.
   task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last);
      int tries;
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      tries    = 0;
      while (!in_ready && tries < 100) begin
         @(negedge clk);
         tries++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Count edges from the last-beat accept until out_valid rises.
   task automatic waitResult(output int edges);
      edges = 0;
      while (!out_valid && edges < 50) begin
         @(posedge clk);
         #1;
         edges++;
         if (!out_valid) checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
      end
      if (!out_valid) checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic checkResult(input int sum, input int count, input int ovf);
      checkOutput("out_sum", 32'(out_sum), 32'(sum));
      checkOutput("out_count", 32'(out_count), 32'(count));
      checkOutput("out_ovf", 32'(out_ovf), 32'(ovf));
      checkOutput("in_ready_output", 32'(in_ready), 32'd0);
   endtask

   task automatic doHandshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
      checkOutput("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int edges;
      int bad;

      #2;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
      checkOutput("reset_out_count", 32'(out_count), 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("release_in_ready", 32'(in_ready), 32'd1);

      // 200 + 200 + 200, latency NCH+1 = 4 edges
      applyStimulus(8'd200, 1'b0);
      applyStimulus(8'd200, 1'b0);
      applyStimulus(8'd200, 1'b1);
      waitResult(edges);
      checkOutput("latency", 32'(edges), 32'd4);
      checkResult(600, 3, 0);
      doHandshake();

      // 16 x 255 = 4080, no overflow
      for (int i = 0; i < 16; i++) applyStimulus(8'd255, i == 15);
      waitResult(edges);
      checkResult(4080, 16, 0);
      doHandshake();

      // 17 x 255 = 4335 -> 239 with overflow
      for (int i = 0; i < 17; i++) applyStimulus(8'd255, i == 16);
      waitResult(edges);
      checkResult(239, 17, 1);
      doHandshake();

      // single-beat frame, then a fresh frame with no residue
      applyStimulus(8'hAB, 1'b1);
      waitResult(edges);
      checkResult(171, 1, 0);
      doHandshake();
      applyStimulus(8'd1, 1'b0);
      applyStimulus(8'd2, 1'b1);
      waitResult(edges);
      checkResult(3, 2, 0);
      doHandshake();

      // input gaps in ACCUM and 10 cycles of output backpressure
      applyStimulus(8'd10, 1'b0);
      repeat (3) @(negedge clk);
      applyStimulus(8'd20, 1'b0);
      repeat (2) @(negedge clk);
      applyStimulus(8'd30, 1'b1);
      waitResult(edges);
      checkResult(60, 3, 0);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!out_valid || out_sum != 12'd60 || out_count != 8'd3 || out_ovf || in_ready) bad++;
      end
      checkOutput("hold_stable", 32'(bad), 32'd0);
      doHandshake();

      // reset during the second RESOLVE cycle discards the frame
      applyStimulus(8'd5, 1'b0);
      applyStimulus(8'd9, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
      checkOutput("rst_out_count", 32'(out_count), 32'd0);
      checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_release_ready", 32'(in_ready), 32'd1);
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      checkOutput("rst_no_result", 32'(bad), 32'd0);
      applyStimulus(8'd5, 1'b0);
      applyStimulus(8'd7, 1'b1);
      waitResult(edges);
      checkResult(12, 2, 0);
      doHandshake();

      // 6 x 1: full count on the default instance, saturated on CNT_W = 2
      for (int i = 0; i < 6; i++) applyStimulus(8'd1, i == 5);
      waitResult(edges);
      checkResult(6, 6, 0);
      checkOutput("sat_out_valid", 32'(out_valid2), 32'd1);
      checkOutput("sat_out_sum", 32'(out_sum2), 32'd6);
      checkOutput("sat_out_count", 32'(out_count2), 32'd3);
      checkOutput("sat_out_ovf", 32'(out_ovf2), 32'd0);
      doHandshake();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
